// File: rtl/uart_word_packer_if.sv
// Byte-in / word-out bundle between the UART receiver, the word packer and the
// DNN load logic. The packer uses the master modport; the consumer side uses slave.
interface uart_word_packer_if #(
    parameter int BYTES_PER_WORD = 2,
    parameter int FIFO_DEPTH     = 16
);
    localparam int WORD_W = 8 * BYTES_PER_WORD;
    localparam int FILL_W = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]        rx_data;
    logic              rx_done;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              word_ready;
    logic [FILL_W-1:0] fill;
    logic              overflow;
    logic              frame_err;

    modport master (
        input  rx_data, rx_done, word_ready,
        output word_out, word_valid, fill, overflow, frame_err
    );

    modport slave (
        output rx_data, rx_done, word_ready,
        input  word_out, word_valid, fill, overflow, frame_err
    );
endinterface

// File: rtl/uart_word_packer.sv
// Packs UART bytes LSB-first into words, queues finished words in a FIFO and
// hands them out on a valid/ready port. A partial word that sits idle for
// TIMEOUT_CYCLES clocks is thrown away so a lost byte cannot shift every
// following word.
//
//  state        | meaning
//  -------------+---------------------------------------------------
//  ST_IDLE      | byte index 0, no partial word held
//  ST_ASSEMBLE  | at least one byte of the current word received
module uart_word_packer #(
    parameter int BYTES_PER_WORD = 2,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic CLK100MHZ,
    input  logic CPU_RESETN,
    uart_word_packer_if.master bus
);
    localparam int WORD_W = 8 * BYTES_PER_WORD;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FILL_W = PTR_W + 1;
    localparam int IDX_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Counter value in the cycle whose edge makes it reach TIMEOUT_CYCLES.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_EN ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES_PER_WORD - 1);

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_ASSEMBLE = 1'b1;

    logic [0:0]        state;
    logic              rx_done_q;
    logic              byte_accept;
    logic              last_byte;
    logic              word_push;
    logic              tmo_hit;
    logic [IDX_W-1:0]  byte_idx;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [WORD_W-1:0] assembly;
    logic [WORD_W-1:0] word_next;

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FILL_W-1:0] fill;
    logic              full;
    logic              valid;
    logic              pop;
    logic              push_ok;
    logic              overflow;
    logic              frame_err;

    // A DONE held for several cycles counts once: only its rising edge accepts a byte.
    assign byte_accept = bus.rx_done & ~rx_done_q;
    assign last_byte   = (byte_idx == IDX_LAST);
    assign word_push   = byte_accept & last_byte;
    // A byte arriving in the expiry cycle takes priority over the timeout.
    assign tmo_hit     = TMO_EN && (state == ST_ASSEMBLE) && (tmo_cnt == TMO_LAST) && !byte_accept;

    assign valid   = (fill != '0);
    assign full    = (fill == FILL_W'(FIFO_DEPTH));
    assign pop     = valid & bus.word_ready;
    assign push_ok = word_push & (~full | pop);

    assign bus.word_valid = valid;
    assign bus.word_out   = valid ? mem[rd_ptr] : '0;
    assign bus.fill       = fill;
    assign bus.overflow   = overflow;
    assign bus.frame_err  = frame_err;

    // Drop the incoming byte into its lane of the partially assembled word.
    always_comb begin
        word_next = assembly;
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            if (byte_idx == IDX_W'(k)) begin
                word_next[8*k +: 8] = bus.rx_data;
            end
        end
    end

    // Remember the previous DONE level for edge detection.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            rx_done_q <= 1'b0;
        end else begin
            rx_done_q <= bus.rx_done;
        end
    end

    // Assembly FSM: byte index, partial word, inter-byte timer and frame error pulse.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state     <= ST_IDLE;
            byte_idx  <= '0;
            assembly  <= '0;
            tmo_cnt   <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (byte_accept) begin
                assembly <= word_next;
                tmo_cnt  <= '0;
                if (last_byte) begin
                    state    <= ST_IDLE;
                    byte_idx <= '0;
                end else begin
                    state    <= ST_ASSEMBLE;
                    byte_idx <= byte_idx + IDX_W'(1);
                end
            end else if (tmo_hit) begin
                state     <= ST_IDLE;
                byte_idx  <= '0;
                tmo_cnt   <= '0;
                frame_err <= 1'b1;
            end else if (state == ST_ASSEMBLE) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
        end
    end

    // FIFO storage; contents need no reset because fill gates visibility.
    always_ff @(posedge CLK100MHZ) begin
        if (push_ok) begin
            mem[wr_ptr] <= word_next;
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   fill <= fill + FILL_W'(1);
                2'b01:   fill <= fill - FILL_W'(1);
                default: fill <= fill;
            endcase
            if (word_push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule
